proyecto_final_fase1: RTL and testbench
=======================================

// Module: proyecto_final_fase1
// PURPOSE
//  Top level of the Phase-1 single-cycle MIPS-subset processor: PC, instruction memory,
//  register file, control/ALU-control and ALU executing R-type instructions only.
//  Self-contained: the bench drives only clock and reset.
//  Program loads by $readmemb into hierarchical array <inst>.MemInst.INS.
// PARAMETERS
//  IMEM_BYTES  256  instruction memory size in bytes (power of 2)
//  DATA_W      32   datapath / register width
// PORTS
//  clk         input   1   system clock, all state updates on rising edge
//  rst         input   1   asynchronous, active-high reset
//  pc          output  32  current program counter
//  alu_result  output  32  combinational ALU result of the current instruction
// BEHAVIOUR
//  - One clock; reset asynchronous and active-high.
//  - rst=1 (any time, async): pc=0, all 32 registers=0, so alu_result=0 while held.
//  - Instruction memory is not reset.
//  - Memory: reg [7:0] INS [0:IMEM_BYTES-1] in sub-module instance MemInst.
//  - Fetch is combinational, big-endian: instr = {INS[pc],INS[pc+1],INS[pc+2],INS[pc+3]}.
//  - Byte addresses taken modulo IMEM_BYTES.
//  - PC: pc <= pc+4 every rising edge when rst=0.
//  - Wraps to 0 after IMEM_BYTES-4; no branches or jumps in this phase.
//  - Decode: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0]; shamt ignored.
//  - op=000000, funct decode (ALU result into rd):
//      100000 add  rs+rt
//      100010 sub  rs-rt
//      100100 and  rs&rt
//      100101 or   rs|rt
//      100111 nor  ~(rs|rt)
//      101010 slt  signed rs<rt ? 1 : 0
//  - Any other funct, or op!=0: NOP. RegWrite=0, alu_result=0, pc still advances.
//  - Arithmetic is 32-bit modulo 2^32; overflow ignored, no trap.
//  - Register file: 32x32.
//      Two combinational read ports (rs, rt).
//      One write port on rising edge when RegWrite=1.
//      $0 reads 0 always; writes to rd=0 discarded.
//  - Same-cycle read/write of a register: reads return the old value; new value visible next cycle.
//  - Uninitialised INS bytes (X) give X decode.
//      No recovery required.
//      Programs must be fully loaded.
// STRUCTURE
//  - Shared package/include: opcode R_TYPE, funct codes above, 4-bit ALU op codes (AND,OR,ADD,SUB,SLT,NOR).
//  - Required sub-module: mem_inst, instantiated as MemInst with array name INS.
//  - Register file, control, ALU control and ALU: separate small modules or inline; internal names free.
// TESTING
//  - Reset: assert rst mid-run -> pc=0 and registers 0 immediately; release -> pc=0,4,8 on successive edges.
//  - Preloaded regs $1=5, $2=3: add $3,$1,$2 -> $3=8.
//      Then sub $4,$1,$2 -> $4=2.
//  - Same operands: and -> 1, or -> 7, nor -> 0xFFFFFFF8.
//  - slt signed with $5=0xFFFFFFFF, $6=1: slt $7,$5,$6 -> 1; slt $7,$6,$5 -> 0.
//  - add $0,$1,$2 -> $0 stays 0.
//  - Unknown funct 111111 or op=001000 -> no register change, pc+4.
//  - Wrap-around: add 0x7FFFFFFF+1 -> 0x80000000.
//  - Run past last word: pc wraps to 0 after IMEM_BYTES-4.

Source files
------------

// File: rtl/proyecto_final_fase1_pkg.sv
// Shared definitions for the Phase-1 single-cycle MIPS-subset processor.
//   - opcode and funct encodings of the supported R-type instructions
//   - 4-bit ALU operation codes
//   - alu_control(): maps (op, funct) to an ALU operation, ALU_NOP when unsupported
package proyecto_final_fase1_pkg;

   localparam logic [5:0] OP_R_TYPE  = 6'b000000;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;

   // ALU_NOP is an extra code: it marks an instruction that must neither
   // produce a result nor write the register file.
   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100,
      ALU_NOP = 4'b1111
   } alu_op_t;

   // Instruction fields of an R-type word; shamt is carried but never used.
   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] funct;
   } r_instr_t;

   function automatic alu_op_t alu_control(input logic [5:0] op, input logic [5:0] funct);
      alu_op_t sel;
      sel = ALU_NOP;
      if (op == OP_R_TYPE) begin
         case (funct)
            FUNCT_ADD: sel = ALU_ADD;
            FUNCT_SUB: sel = ALU_SUB;
            FUNCT_AND: sel = ALU_AND;
            FUNCT_OR:  sel = ALU_OR;
            FUNCT_NOR: sel = ALU_NOR;
            FUNCT_SLT: sel = ALU_SLT;
            default:   sel = ALU_NOP;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/mem_inst.sv
// Byte-wide instruction memory with a combinational big-endian word fetch.
// Ports:
//   clk      input   clock for the optional byte load port
//   wr_en    input   byte load enable (tied low in normal operation)
//   wr_addr  input   byte load address
//   wr_data  input   byte load data
//   addr     input   fetch byte address (wraps modulo IMEM_BYTES)
//   instr    output  {INS[addr], INS[addr+1], INS[addr+2], INS[addr+3]}
// The array is not reset; programs are placed into INS from outside.
module mem_inst #(
   parameter int IMEM_BYTES = 256,
   parameter int ADDR_W     = $clog2(IMEM_BYTES)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] addr,
   output logic [31:0]       instr
);

   logic [7:0] INS [0:IMEM_BYTES-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         INS[wr_addr] <= wr_data;
      end
   end

   // Each byte address is computed in ADDR_W bits so it wraps naturally.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte
         logic [ADDR_W-1:0] byte_addr;
         assign byte_addr           = addr + ADDR_W'(gi);
         assign instr[31-8*gi -: 8] = INS[byte_addr];
      end
   endgenerate

endmodule

// File: rtl/proyecto_final_fase1_alu.sv
// Combinational ALU for the supported R-type operations.
// Ports:
//   a, b     input   operands (rs, rt)
//   alu_op   input   operation select
//   result   output  operation result; zero for ALU_NOP
// Arithmetic wraps modulo 2^DATA_W; SLT compares as signed.
module proyecto_final_fase1_alu
   import proyecto_final_fase1_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu_op_t           alu_op,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = '0;
      case (alu_op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_NOR: result = ~(a | b);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/proyecto_final_fase1.sv
// Phase-1 single-cycle MIPS-subset processor (R-type only).
// Ports:
//   clk         input   system clock, rising edge
//   rst         input   asynchronous active-high reset (pc and registers to 0)
//   pc          output  current program counter
//   alu_result  output  combinational ALU result of the current instruction
// Every cycle the word at pc is decoded, executed and (if supported) written
// back to rd on the next rising edge, while pc steps by 4 and wraps to 0.
module proyecto_final_fase1
   import proyecto_final_fase1_pkg::*;
#(
   parameter int IMEM_BYTES = 256,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic [31:0]       pc,
   output logic [DATA_W-1:0] alu_result
);

   localparam int ADDR_W = $clog2(IMEM_BYTES);
   localparam logic [31:0] PC_LAST = 32'(IMEM_BYTES - 4);

   logic [31:0]       instr;
   r_instr_t          fields;
   alu_op_t           alu_op;
   logic              reg_write;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [DATA_W-1:0] regs [0:31];

   // ---------------- fetch ----------------
   mem_inst #(
      .IMEM_BYTES(IMEM_BYTES),
      .ADDR_W    (ADDR_W)
   ) MemInst (
      .clk    (clk),
      .wr_en  (1'b0),
      .wr_addr('0),
      .wr_data(8'h00),
      .addr   (pc[ADDR_W-1:0]),
      .instr  (instr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= '0;
      end else begin
         pc <= (pc == PC_LAST) ? 32'd0 : pc + 32'd4;
      end
   end

   // ---------------- decode ----------------
   assign fields    = r_instr_t'(instr);
   assign alu_op    = alu_control(fields.op, fields.funct);
   assign reg_write = (alu_op != ALU_NOP);

   // ---------------- register file ----------------
   // Reads are combinational, so an instruction writing the register it reads
   // sees the old value; the new one appears after the edge.
   assign rs_val = (fields.rs == 5'd0) ? '0 : regs[fields.rs];
   assign rt_val = (fields.rt == 5'd0) ? '0 : regs[fields.rt];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (reg_write && (fields.rd != 5'd0)) begin
         regs[fields.rd] <= alu_result;
      end
   end

   // ---------------- execute ----------------
   proyecto_final_fase1_alu #(
      .DATA_W(DATA_W)
   ) u_alu (
      .a     (rs_val),
      .b     (rt_val),
      .alu_op(alu_op),
      .result(alu_result)
   );

endmodule

// File: tb/tb_proyecto_final_fase1.sv
// Directed self-checking bench for proyecto_final_fase1. Programs and initial
// register values are placed through hierarchical access; expected values are
// hand-computed constants.
module tb_proyecto_final_fase1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc;
   logic [31:0] alu_result;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_NOR = 6'b100111;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_BAD = 6'b111111;

   proyecto_final_fase1 #(.IMEM_BYTES(256), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] funct);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, funct};
   endfunction

   // Hold reset, clear memory to NOP words (all zero decodes as NOP).
   task automatic begin_prog();
      @(negedge clk);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 256; i++) dut.MemInst.INS[i] = 8'h00;
   endtask

   task automatic put(input int addr, input logic [31:0] w);
      dut.MemInst.INS[addr]   = w[31:24];
      dut.MemInst.INS[addr+1] = w[23:16];
      dut.MemInst.INS[addr+2] = w[15:8];
      dut.MemInst.INS[addr+3] = w[7:0];
   endtask

   // Release reset at a falling edge; caller then preloads registers.
   task automatic go();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      begin_prog();
      put(0, rtype(1, 2, 3, F_ADD));
      go();
      dut.regs[1] = 32'd5;
      dut.regs[2] = 32'd3;
      step();
      n_checks++; if (dut.regs[3] !== 32'd8) begin n_fail++; $display("FAIL reset_pre_r3: got %h want %h", dut.regs[3], 32'd8); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_async_pc: got %h want %h", pc, 32'd0); end
      n_checks++; if (dut.regs[3] !== 32'd0) begin n_fail++; $display("FAIL reset_async_r3: got %h want %h", dut.regs[3], 32'd0); end
      n_checks++; if (dut.regs[1] !== 32'd0) begin n_fail++; $display("FAIL reset_async_r1: got %h want %h", dut.regs[1], 32'd0); end
      n_checks++; if (alu_result !== 32'd0) begin n_fail++; $display("FAIL reset_alu: got %h want %h", alu_result, 32'd0); end
      step();
      n_checks++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_held_pc: got %h want %h", pc, 32'd0); end
      rst = 1'b0;
      #1;
      n_checks++; if (pc !== 32'd0) begin n_fail++; $display("FAIL release_pc0: got %h want %h", pc, 32'd0); end
      step();
      n_checks++; if (pc !== 32'd4) begin n_fail++; $display("FAIL release_pc4: got %h want %h", pc, 32'd4); end
      step();
      n_checks++; if (pc !== 32'd8) begin n_fail++; $display("FAIL release_pc8: got %h want %h", pc, 32'd8); end
      $display("test_reset done pc=%h", pc);
   endtask

   task automatic test_add_sub();
      begin_prog();
      put(0, rtype(1, 2, 3, F_ADD));
      put(4, rtype(1, 2, 4, F_SUB));
      go();
      dut.regs[1] = 32'd5;
      dut.regs[2] = 32'd3;
      #1;
      n_checks++; if (alu_result !== 32'd8) begin n_fail++; $display("FAIL add_alu: got %h want %h", alu_result, 32'd8); end
      $display("add $3,$1,$2 pc=%h alu=%h", pc, alu_result);
      step();
      n_checks++; if (dut.regs[3] !== 32'd8) begin n_fail++; $display("FAIL add_r3: got %h want %h", dut.regs[3], 32'd8); end
      n_checks++; if (alu_result !== 32'd2) begin n_fail++; $display("FAIL sub_alu: got %h want %h", alu_result, 32'd2); end
      $display("sub $4,$1,$2 pc=%h alu=%h", pc, alu_result);
      step();
      n_checks++; if (dut.regs[4] !== 32'd2) begin n_fail++; $display("FAIL sub_r4: got %h want %h", dut.regs[4], 32'd2); end
   endtask

   task automatic test_logic();
      begin_prog();
      put(0, rtype(1, 2, 3, F_AND));
      put(4, rtype(1, 2, 4, F_OR));
      put(8, rtype(1, 2, 5, F_NOR));
      go();
      dut.regs[1] = 32'd5;
      dut.regs[2] = 32'd3;
      #1;
      n_checks++; if (alu_result !== 32'd1) begin n_fail++; $display("FAIL and_alu: got %h want %h", alu_result, 32'd1); end
      $display("and $3,$1,$2 alu=%h", alu_result);
      step();
      n_checks++; if (alu_result !== 32'd7) begin n_fail++; $display("FAIL or_alu: got %h want %h", alu_result, 32'd7); end
      $display("or  $4,$1,$2 alu=%h", alu_result);
      step();
      n_checks++; if (alu_result !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL nor_alu: got %h want %h", alu_result, 32'hFFFF_FFF8); end
      $display("nor $5,$1,$2 alu=%h", alu_result);
      step();
      n_checks++; if (dut.regs[3] !== 32'd1) begin n_fail++; $display("FAIL and_r3: got %h want %h", dut.regs[3], 32'd1); end
      n_checks++; if (dut.regs[4] !== 32'd7) begin n_fail++; $display("FAIL or_r4: got %h want %h", dut.regs[4], 32'd7); end
      n_checks++; if (dut.regs[5] !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL nor_r5: got %h want %h", dut.regs[5], 32'hFFFF_FFF8); end
   endtask

   task automatic test_slt();
      begin_prog();
      put(0, rtype(5, 6, 7, F_SLT));
      put(4, rtype(6, 5, 7, F_SLT));
      go();
      dut.regs[5] = 32'hFFFF_FFFF;
      dut.regs[6] = 32'd1;
      #1;
      n_checks++; if (alu_result !== 32'd1) begin n_fail++; $display("FAIL slt_neg_lt_pos: got %h want %h", alu_result, 32'd1); end
      $display("slt $7,$5,$6 alu=%h", alu_result);
      step();
      n_checks++; if (dut.regs[7] !== 32'd1) begin n_fail++; $display("FAIL slt_r7_one: got %h want %h", dut.regs[7], 32'd1); end
      n_checks++; if (alu_result !== 32'd0) begin n_fail++; $display("FAIL slt_pos_lt_neg: got %h want %h", alu_result, 32'd0); end
      $display("slt $7,$6,$5 alu=%h", alu_result);
      step();
      n_checks++; if (dut.regs[7] !== 32'd0) begin n_fail++; $display("FAIL slt_r7_zero: got %h want %h", dut.regs[7], 32'd0); end
   endtask

   task automatic test_zero_reg();
      begin_prog();
      put(0, rtype(1, 2, 0, F_ADD));
      put(4, rtype(0, 1, 9, F_ADD));
      go();
      dut.regs[1] = 32'd5;
      dut.regs[2] = 32'd3;
      step();
      n_checks++; if (dut.regs[0] !== 32'd0) begin n_fail++; $display("FAIL zero_r0: got %h want %h", dut.regs[0], 32'd0); end
      n_checks++; if (alu_result !== 32'd5) begin n_fail++; $display("FAIL zero_read: got %h want %h", alu_result, 32'd5); end
      $display("add $0,$1,$2 then add $9,$0,$1 alu=%h", alu_result);
   endtask

   task automatic test_nop();
      begin_prog();
      put(0, rtype(1, 2, 3, F_BAD));
      put(4, {6'b001000, 5'd1, 5'd3, 16'h0011});
      go();
      dut.regs[1] = 32'd5;
      dut.regs[2] = 32'd3;
      dut.regs[3] = 32'h0000_1234;
      #1;
      n_checks++; if (alu_result !== 32'd0) begin n_fail++; $display("FAIL nop_funct_alu: got %h want %h", alu_result, 32'd0); end
      step();
      n_checks++; if (dut.regs[3] !== 32'h0000_1234) begin n_fail++; $display("FAIL nop_funct_r3: got %h want %h", dut.regs[3], 32'h0000_1234); end
      n_checks++; if (pc !== 32'd4) begin n_fail++; $display("FAIL nop_funct_pc: got %h want %h", pc, 32'd4); end
      n_checks++; if (alu_result !== 32'd0) begin n_fail++; $display("FAIL nop_op_alu: got %h want %h", alu_result, 32'd0); end
      step();
      n_checks++; if (dut.regs[3] !== 32'h0000_1234) begin n_fail++; $display("FAIL nop_op_r3: got %h want %h", dut.regs[3], 32'h0000_1234); end
      n_checks++; if (pc !== 32'd8) begin n_fail++; $display("FAIL nop_op_pc: got %h want %h", pc, 32'd8); end
      $display("nop sequence pc=%h r3=%h", pc, dut.regs[3]);
   endtask

   task automatic test_overflow();
      begin_prog();
      put(0, rtype(1, 2, 3, F_ADD));
      go();
      dut.regs[1] = 32'h7FFF_FFFF;
      dut.regs[2] = 32'd1;
      #1;
      n_checks++; if (alu_result !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_alu: got %h want %h", alu_result, 32'h8000_0000); end
      step();
      n_checks++; if (dut.regs[3] !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_r3: got %h want %h", dut.regs[3], 32'h8000_0000); end
      $display("add 7fffffff+1 r3=%h", dut.regs[3]);
   endtask

   task automatic test_back_to_back();
      begin_prog();
      put(0, rtype(1, 2, 1, F_ADD));
      put(4, rtype(1, 2, 3, F_ADD));
      put(8, rtype(3, 3, 4, F_ADD));
      go();
      dut.regs[1] = 32'd5;
      dut.regs[2] = 32'd3;
      #1;
      n_checks++; if (alu_result !== 32'd8) begin n_fail++; $display("FAIL b2b_old_read: got %h want %h", alu_result, 32'd8); end
      step();
      n_checks++; if (alu_result !== 32'd11) begin n_fail++; $display("FAIL b2b_new_r1: got %h want %h", alu_result, 32'd11); end
      step();
      n_checks++; if (alu_result !== 32'd22) begin n_fail++; $display("FAIL b2b_new_r3: got %h want %h", alu_result, 32'd22); end
      $display("back_to_back final alu=%h", alu_result);
   endtask

   task automatic test_wrap();
      begin_prog();
      put(252, rtype(1, 2, 3, F_ADD));
      go();
      dut.regs[1] = 32'd5;
      dut.regs[2] = 32'd3;
      repeat (63) step();
      n_checks++; if (pc !== 32'd252) begin n_fail++; $display("FAIL wrap_last_pc: got %h want %h", pc, 32'd252); end
      n_checks++; if (alu_result !== 32'd8) begin n_fail++; $display("FAIL wrap_last_alu: got %h want %h", alu_result, 32'd8); end
      step();
      n_checks++; if (pc !== 32'd0) begin n_fail++; $display("FAIL wrap_pc0: got %h want %h", pc, 32'd0); end
      n_checks++; if (dut.regs[3] !== 32'd8) begin n_fail++; $display("FAIL wrap_r3: got %h want %h", dut.regs[3], 32'd8); end
      $display("wrap pc=%h", pc);
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic();
      test_slt();
      test_zero_reg();
      test_nop();
      test_overflow();
      test_back_to_back();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
